// File: rtl/label_dispatch_ctrl_pkg.sv
// Shared types and default sizing for the label dispatch controller.
package label_dispatch_ctrl_pkg;

  localparam int DEF_SEL_W      = 3;
  localparam int DEF_RES_W      = 3;
  localparam int DEF_NUM_LABELS = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/label_dispatch_ctrl_if.sv
// Config, request and response signals of the label dispatch controller.
interface label_dispatch_ctrl_if
  import label_dispatch_ctrl_pkg::*;
#(
  parameter int SEL_W      = DEF_SEL_W,
  parameter int RES_W      = DEF_RES_W,
  parameter int NUM_LABELS = DEF_NUM_LABELS
);
  localparam int IDX_W = $clog2(NUM_LABELS);

  logic             cfg_we;
  logic [IDX_W-1:0] cfg_idx;
  logic             cfg_en;
  logic [SEL_W-1:0] cfg_label;
  logic [RES_W-1:0] cfg_result;

  logic             req_valid;
  logic             req_ready;
  logic [SEL_W-1:0] req_sel;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [RES_W-1:0] rsp_result;
  logic             rsp_hit;
  logic [IDX_W-1:0] rsp_idx;

  modport master (
    output cfg_we, cfg_idx, cfg_en, cfg_label, cfg_result,
    output req_valid, req_sel, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_hit, rsp_idx
  );

  modport slave (
    input  cfg_we, cfg_idx, cfg_en, cfg_label, cfg_result,
    input  req_valid, req_sel, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_hit, rsp_idx
  );

endinterface

// File: rtl/label_dispatch_ctrl_table.sv
// Label table: per-entry registers with a synchronous write port and a
// combinational indexed read that performs the exact 4-state label compare.
module label_table
  import label_dispatch_ctrl_pkg::*;
#(
  parameter int SEL_W      = DEF_SEL_W,
  parameter int RES_W      = DEF_RES_W,
  parameter int NUM_LABELS = DEF_NUM_LABELS,
  localparam int IDX_W     = $clog2(NUM_LABELS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_enable,
  input  logic [SEL_W-1:0] wr_label,
  input  logic [RES_W-1:0] wr_result,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [SEL_W-1:0] rd_sel,
  output logic             rd_match,
  output logic [RES_W-1:0] rd_result
);

  logic             entry_en     [NUM_LABELS];
  logic [SEL_W-1:0] entry_label  [NUM_LABELS];
  logic [RES_W-1:0] entry_result [NUM_LABELS];

  for (genvar gi = 0; gi < NUM_LABELS; gi++) begin : g_entry
    logic             en_reg;
    logic [SEL_W-1:0] label_reg;
    logic [RES_W-1:0] result_reg;

    always_ff @(posedge clk) begin
      if (reset) begin
        en_reg     <= 1'b0;
        label_reg  <= '0;
        result_reg <= '0;
      end else if (wr_en && (wr_idx == IDX_W'(gi))) begin
        en_reg     <= wr_enable;
        label_reg  <= wr_label;
        result_reg <= wr_result;
      end
    end

    assign entry_en[gi]     = en_reg;
    assign entry_label[gi]  = label_reg;
    assign entry_result[gi] = result_reg;
  end

  // Case equality so that x and z label bits only match the same symbol.
  assign rd_match  = entry_en[rd_idx] && (entry_label[rd_idx] === rd_sel);
  assign rd_result = entry_result[rd_idx];

endmodule

// File: rtl/label_dispatch_ctrl.sv
// Sequential label dispatcher: scans the label table one entry per cycle and
// returns the result of the lowest-index enabled entry whose label matches.
module label_dispatch_ctrl
  import label_dispatch_ctrl_pkg::*;
#(
  parameter int SEL_W      = DEF_SEL_W,
  parameter int RES_W      = DEF_RES_W,
  parameter int NUM_LABELS = DEF_NUM_LABELS
) (
  input  logic                 clk,
  input  logic                 reset,
  label_dispatch_ctrl_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_LABELS);

  state_e           state_reg;
  state_e           state_next;
  logic [IDX_W-1:0] scan_idx_reg;
  logic [SEL_W-1:0] sel_reg;
  logic [RES_W-1:0] last_result_reg;
  logic [RES_W-1:0] rsp_result_reg;
  logic [IDX_W-1:0] rsp_idx_reg;
  logic             rsp_hit_reg;

  logic             tbl_match;
  logic [RES_W-1:0] tbl_result;
  logic             scan_last;
  logic             req_ready;
  logic             rsp_valid;
  logic             accept;
  logic             rsp_fire;

  label_table #(
    .SEL_W      (SEL_W),
    .RES_W      (RES_W),
    .NUM_LABELS (NUM_LABELS)
  ) u_table (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (bus.cfg_we),
    .wr_idx    (bus.cfg_idx),
    .wr_enable (bus.cfg_en),
    .wr_label  (bus.cfg_label),
    .wr_result (bus.cfg_result),
    .rd_idx    (scan_idx_reg),
    .rd_sel    (sel_reg),
    .rd_match  (tbl_match),
    .rd_result (tbl_result)
  );

  assign scan_last = (scan_idx_reg == IDX_W'(NUM_LABELS - 1));
  assign accept    = bus.req_valid && req_ready;
  assign rsp_fire  = rsp_valid && bus.rsp_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = SCAN;
      SCAN: if (tbl_match || scan_last) state_next = RESP;
      RESP: if (rsp_fire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_reg)
      IDLE:    req_ready = 1'b1;
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // A miss reports the previous hit's result, like a case with no default arm.
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_idx_reg    <= '0;
      sel_reg         <= '0;
      last_result_reg <= '0;
      rsp_result_reg  <= '0;
      rsp_idx_reg     <= '0;
      rsp_hit_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            sel_reg      <= bus.req_sel;
            scan_idx_reg <= '0;
          end
        end
        SCAN: begin
          if (tbl_match) begin
            rsp_hit_reg     <= 1'b1;
            rsp_idx_reg     <= scan_idx_reg;
            rsp_result_reg  <= tbl_result;
            last_result_reg <= tbl_result;
          end else if (scan_last) begin
            rsp_hit_reg    <= 1'b0;
            rsp_idx_reg    <= '0;
            rsp_result_reg <= last_result_reg;
          end else begin
            scan_idx_reg <= scan_idx_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.rsp_valid  = rsp_valid;
  assign bus.rsp_hit    = rsp_hit_reg;
  assign bus.rsp_idx    = rsp_idx_reg;
  assign bus.rsp_result = rsp_result_reg;

endmodule

// File: tb/tb_label_dispatch_ctrl.sv
// Directed bench for label_dispatch_ctrl: dispatch, miss, priority,
// back-pressure, reset mid-scan and write-during-scan scenarios.
module tb_label_dispatch_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  label_dispatch_ctrl_if bus ();

  label_dispatch_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // 4-state selectors; a 2-state simulator gets distinct 2-state stand-ins
  logic       two_state;
  logic [2:0] sel_x11, sel_z11, sel_miss, sel_allx;

  int         r_edges;
  logic       r_hit;
  logic [2:0] r_idx, r_result;

  task automatic cfg_write(input logic [2:0] idx, input logic en,
                           input logic [2:0] label, input logic [2:0] result);
    bus.cfg_we = 1'b1; bus.cfg_idx = idx; bus.cfg_en = en;
    bus.cfg_label = label; bus.cfg_result = result;
    @(posedge clk); #1;
    bus.cfg_we = 1'b0;
  endtask

  // Issue one request, optionally writing a table entry during cycle wr_at
  // (counted from the accept edge), and complete the response handshake.
  task automatic do_request(input logic [2:0] sel, input int wr_at,
                            input logic [2:0] wr_idx, input logic [2:0] wr_label,
                            input logic [2:0] wr_result);
    r_edges = -1;
    bus.req_valid = 1'b1; bus.req_sel = sel;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.req_sel = sel ^ 3'b101;
    for (int e = 0; e < 20 && r_edges < 0; e++) begin
      bus.cfg_we = (e == wr_at);
      if (e == wr_at) begin
        bus.cfg_idx = wr_idx; bus.cfg_en = 1'b1;
        bus.cfg_label = wr_label; bus.cfg_result = wr_result;
      end
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) r_edges = e;
      else begin @(posedge clk); #1; end
    end
    bus.cfg_we = 1'b0;
    r_hit = bus.rsp_hit; r_idx = bus.rsp_idx; r_result = bus.rsp_result;
    if (r_edges >= 0) begin
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.cfg_we = 1'b1; bus.cfg_idx = 3'd0; bus.cfg_en = 1'b1;
    bus.cfg_label = 3'b000; bus.cfg_result = 3'd7;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0; bus.cfg_we = 1'b0;
    @(negedge clk);
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL reset req_ready: got %b want 1", bus.req_ready); end
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset rsp_valid: got %b want 0", bus.rsp_valid); end
    total++; if (bus.rsp_hit !== 1'b0) begin bad++; $display("FAIL reset rsp_hit: got %b want 0", bus.rsp_hit); end
    total++; if (bus.rsp_idx !== 3'd0) begin bad++; $display("FAIL reset rsp_idx: got %0d want 0", bus.rsp_idx); end
    total++; if (bus.rsp_result !== 3'd0) begin bad++; $display("FAIL reset rsp_result: got %0d want 0", bus.rsp_result); end
    @(posedge clk); #1;
    // the write that coincided with reset must not have landed in entry 0
    do_request(3'b000, -1, 3'd0, 3'b000, 3'd0);
    total++; if (r_hit !== 1'b0 || r_result !== 3'd0 || r_edges != 8) begin
      bad++; $display("FAIL reset_vs_cfg: got hit=%b result=%0d edges=%0d want hit=0 result=0 edges=8", r_hit, r_result, r_edges);
    end
    $display("reset: done, empty-table request edges=%0d", r_edges);
  endtask

  task automatic test_disabled();
    cfg_write(3'd6, 1'b0, sel_allx, 3'd7);
    do_request(sel_allx, -1, 3'd0, 3'b000, 3'd0);
    total++; if (r_hit !== 1'b0) begin bad++; $display("FAIL disabled rsp_hit: got %b want 0", r_hit); end
    total++; if (r_result !== 3'd0 || r_idx !== 3'd0) begin
      bad++; $display("FAIL disabled rsp: got result=%0d idx=%0d want result=0 idx=0", r_result, r_idx);
    end
    $display("disabled: sel=%b hit=%b edges=%0d", sel_allx, r_hit, r_edges);
  endtask

  task automatic test_dispatch();
    logic [2:0] sels [5];
    logic [2:0] exp_res [5];
    logic [2:0] exp_idx [5];
    cfg_write(3'd0, 1'b1, 3'b000, 3'd0);
    cfg_write(3'd1, 1'b1, 3'b001, 3'd1);
    cfg_write(3'd2, 1'b1, 3'b010, 3'd2);
    cfg_write(3'd3, 1'b1, sel_x11, 3'd4);
    cfg_write(3'd4, 1'b1, sel_z11, 3'd5);
    sels    = '{3'b000, 3'b001, 3'b010, sel_z11, sel_x11};
    exp_res = '{3'd0, 3'd1, 3'd2, 3'd5, 3'd4};
    exp_idx = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd3};
    for (int i = 0; i < 5; i++) begin
      do_request(sels[i], -1, 3'd0, 3'b000, 3'd0);
      total++; if (r_hit !== 1'b1) begin bad++; $display("FAIL dispatch[%0d] hit: got %b want 1", i, r_hit); end
      total++; if (r_result !== exp_res[i]) begin bad++; $display("FAIL dispatch[%0d] result: got %0d want %0d", i, r_result, exp_res[i]); end
      total++; if (r_idx !== exp_idx[i]) begin bad++; $display("FAIL dispatch[%0d] idx: got %0d want %0d", i, r_idx, exp_idx[i]); end
      total++; if (r_edges != int'(exp_idx[i]) + 1) begin bad++; $display("FAIL dispatch[%0d] latency: got %0d want %0d", i, r_edges, int'(exp_idx[i]) + 1); end
      $display("dispatch: sel=%b hit=%b idx=%0d result=%0d edges=%0d", sels[i], r_hit, r_idx, r_result, r_edges);
    end
  endtask

  task automatic test_miss();
    do_request(sel_miss, -1, 3'd0, 3'b000, 3'd0);
    total++; if (r_hit !== 1'b0) begin bad++; $display("FAIL miss hit: got %b want 0", r_hit); end
    total++; if (r_result !== 3'd4) begin bad++; $display("FAIL miss result: got %0d want 4", r_result); end
    total++; if (r_idx !== 3'd0) begin bad++; $display("FAIL miss idx: got %0d want 0", r_idx); end
    total++; if (r_edges != 8) begin bad++; $display("FAIL miss latency: got %0d want 8", r_edges); end
    $display("miss: sel=%b hit=%b result=%0d edges=%0d", sel_miss, r_hit, r_result, r_edges);
  endtask

  task automatic test_first_match();
    cfg_write(3'd1, 1'b1, 3'b011, 3'd3);
    cfg_write(3'd5, 1'b1, 3'b011, 3'd6);
    do_request(3'b011, -1, 3'd0, 3'b000, 3'd0);
    total++; if (r_idx !== 3'd1) begin bad++; $display("FAIL first_match idx: got %0d want 1", r_idx); end
    total++; if (r_result !== 3'd3) begin bad++; $display("FAIL first_match result: got %0d want 3", r_result); end
    total++; if (r_edges != 2) begin bad++; $display("FAIL first_match latency: got %0d want 2", r_edges); end
    $display("first_match: idx=%0d result=%0d edges=%0d", r_idx, r_result, r_edges);
  endtask

  task automatic test_back_to_back();
    int seen;
    seen = -1;
    bus.req_valid = 1'b1; bus.req_sel = 3'b010;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    for (int e = 0; e < 20 && seen < 0; e++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) seen = e;
      else begin @(posedge clk); #1; end
    end
    total++; if (seen != 3) begin bad++; $display("FAIL hold latency: got %0d want 3", seen); end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      bus.req_valid = (c % 2 == 0); bus.req_sel = 3'(c);
      @(negedge clk);
      total++; if (bus.rsp_valid !== 1'b1 || bus.req_ready !== 1'b0) begin
        bad++; $display("FAIL hold[%0d] handshake: got rsp_valid=%b req_ready=%b want 1/0", c, bus.rsp_valid, bus.req_ready);
      end
      total++; if (bus.rsp_hit !== 1'b1 || bus.rsp_idx !== 3'd2 || bus.rsp_result !== 3'd2) begin
        bad++; $display("FAIL hold[%0d] rsp: got hit=%b idx=%0d result=%0d want 1/2/2", c, bus.rsp_hit, bus.rsp_idx, bus.rsp_result);
      end
    end
    bus.req_valid = 1'b1; bus.req_sel = 3'b011; bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    total++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      bad++; $display("FAIL after_handshake: got req_ready=%b rsp_valid=%b want 1/0", bus.req_ready, bus.rsp_valid);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    seen = -1;
    for (int e = 0; e < 20 && seen < 0; e++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) seen = e;
      else begin @(posedge clk); #1; end
    end
    total++; if (seen != 2 || bus.rsp_idx !== 3'd1 || bus.rsp_result !== 3'd3) begin
      bad++; $display("FAIL next_request: got edges=%0d idx=%0d result=%0d want 2/1/3", seen, bus.rsp_idx, bus.rsp_result);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
        bad++; $display("FAIL single_accept[%0d]: got req_ready=%b rsp_valid=%b want 1/0", c, bus.req_ready, bus.rsp_valid);
      end
    end
    @(posedge clk); #1;
    $display("back_to_back: held 5 cycles, follow-up edges=%0d", seen);
  endtask

  task automatic test_reset_mid_scan();
    bus.req_valid = 1'b1; bus.req_sel = sel_miss;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    for (int e = 0; e < 3; e++) begin
      @(negedge clk);
      total++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b0) begin
        bad++; $display("FAIL scan_busy[%0d]: got rsp_valid=%b req_ready=%b want 0/0", e, bus.rsp_valid, bus.req_ready);
      end
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    total++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      bad++; $display("FAIL midreset handshake: got req_ready=%b rsp_valid=%b want 1/0", bus.req_ready, bus.rsp_valid);
    end
    total++; if (bus.rsp_hit !== 1'b0 || bus.rsp_idx !== 3'd0 || bus.rsp_result !== 3'd0) begin
      bad++; $display("FAIL midreset rsp: got hit=%b idx=%0d result=%0d want 0/0/0", bus.rsp_hit, bus.rsp_idx, bus.rsp_result);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL midreset quiet[%0d]: got rsp_valid=%b want 0", c, bus.rsp_valid); end
    end
    @(posedge clk); #1;
    do_request(3'b010, -1, 3'd0, 3'b000, 3'd0);
    total++; if (r_hit !== 1'b0 || r_result !== 3'd0 || r_edges != 8) begin
      bad++; $display("FAIL midreset table: got hit=%b result=%0d edges=%0d want 0/0/8", r_hit, r_result, r_edges);
    end
    $display("reset_mid_scan: post-reset request hit=%b result=%0d", r_hit, r_result);
  endtask

  task automatic test_write_during_scan();
    do_request(3'b101, 2, 3'd2, 3'b101, 3'd6);
    total++; if (r_hit !== 1'b0 || r_edges != 8) begin
      bad++; $display("FAIL wscan first: got hit=%b edges=%0d want 0/8", r_hit, r_edges);
    end
    do_request(3'b101, -1, 3'd0, 3'b000, 3'd0);
    total++; if (r_hit !== 1'b1 || r_idx !== 3'd2 || r_result !== 3'd6) begin
      bad++; $display("FAIL wscan second: got hit=%b idx=%0d result=%0d want 1/2/6", r_hit, r_idx, r_result);
    end
    total++; if (r_edges != 3) begin bad++; $display("FAIL wscan latency: got %0d want 3", r_edges); end
    $display("write_during_scan: second hit=%b idx=%0d result=%0d", r_hit, r_idx, r_result);
  endtask

  initial begin
    logic probe;
    probe = 1'bx;
    two_state = (probe === 1'b0) || (probe === 1'b1);
    if (two_state) begin
      sel_x11 = 3'b011; sel_z11 = 3'b111; sel_miss = 3'b110; sel_allx = 3'b000;
    end else begin
      sel_x11 = 3'bx11; sel_z11 = 3'bz11; sel_miss = 3'b111; sel_allx = 3'bxxx;
    end
    reset = 1'b1;
    bus.cfg_we = 1'b0; bus.cfg_idx = '0; bus.cfg_en = 1'b0;
    bus.cfg_label = '0; bus.cfg_result = '0;
    bus.req_valid = 1'b0; bus.req_sel = '0; bus.rsp_ready = 1'b0;
    test_reset();
    test_disabled();
    test_dispatch();
    test_miss();
    test_first_match();
    test_back_to_back();
    test_reset_mid_scan();
    test_write_during_scan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
